// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mdu_ctrl
// Brief   : Iterative multiply/divide unit with HI/LO registers.
// Revision: 1.0
// ============================================================================
module mdu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             divZero
);

    localparam int                 c_cnt_w = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_iter  = c_cnt_w'(WIDTH);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_m;
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     r_q;
    logic                 r_div;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_dz;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic                 w_accept;
    logic                 w_md_op;
    logic                 w_is_div;
    logic                 w_signed;
    logic                 w_b_zero;
    logic                 w_dz;
    logic                 w_mt;
    logic                 w_go;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH:0]       w_add;
    logic [WIDTH:0]       w_shift;
    logic [WIDTH:0]       w_diff;
    logic                 w_ge;
    logic [2*WIDTH-1:0]   w_prod;
    logic [2*WIDTH-1:0]   w_prod_c;
    logic [WIDTH-1:0]     w_fix_hi;
    logic [WIDTH-1:0]     w_fix_lo;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_md_op  = ~op[2];
    assign w_is_div = op[1];
    assign w_signed = op[0];
    assign w_b_zero = (b == '0);
    assign w_dz     = w_accept & w_md_op & w_is_div & w_b_zero;
    assign w_mt     = w_accept & op[2] & ~op[1];
    assign w_go     = w_accept & w_md_op & ~(w_is_div & w_b_zero);

    assign w_a_mag  = (w_signed && a[WIDTH-1]) ? -a : a;
    assign w_b_mag  = (w_signed && b[WIDTH-1]) ? -b : b;

    // Multiply: conditional add into the upper half, then shift {acc,q} right.
    assign w_add    = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : '0);

    // Divide: restoring step; the borrow bit of the trial subtract decides.
    assign w_shift  = {r_acc, r_q[WIDTH-1]};
    assign w_diff   = w_shift - {1'b0, r_m};
    assign w_ge     = ~w_diff[WIDTH];

    assign w_prod   = {r_acc, r_q};
    assign w_prod_c = r_neg_q ? -w_prod : w_prod;
    assign w_fix_hi = r_div ? (r_neg_r ? -r_acc : r_acc) : w_prod_c[2*WIDTH-1:WIDTH];
    assign w_fix_lo = r_div ? (r_neg_q ? -r_q : r_q) : w_prod_c[WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_go) begin
                    w_next = S_RUN;
                end else if (w_dz || w_mt) begin
                    w_next = S_FIN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (r_cnt == c_one) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                busy   = 1'b1;
                w_next = S_FIN;
            end
            default: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_m     <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_m     <= w_b_mag;
                        r_q     <= w_a_mag;
                        r_acc   <= '0;
                        r_cnt   <= c_iter;
                        r_div   <= w_is_div;
                        r_neg_q <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg_r <= w_signed & a[WIDTH-1];
                    end
                    if (w_mt && !op[0]) begin
                        r_hi <= a;
                    end
                    if (w_mt && op[0]) begin
                        r_lo <= a;
                    end
                    if (w_accept) begin
                        r_dz <= w_dz;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt - c_one;
                    if (r_div) begin
                        r_acc <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                        r_q   <= {r_q[WIDTH-2:0], w_ge};
                    end else begin
                        r_acc <= w_add[WIDTH:1];
                        r_q   <= {w_add[0], r_q[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    r_hi <= w_fix_hi;
                    r_lo <= w_fix_lo;
                end
                default: begin
                end
            endcase
        end
    end

    assign hi      = r_hi;
    assign lo      = r_lo;
    assign divZero = done & r_dz;

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mdu_ctrl
// Brief   : Scoreboard bench for mdu_ctrl with directed, hand-computed vectors.
// Revision: 1.0
// ============================================================================
module tb_mdu_ctrl;

    localparam int W     = 32;
    localparam int c_lat = W + 1;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op    = 3'd0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         divZero;

    mdu_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
        .divZero (divZero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           cyc;
        int           busy;
    } exp_t;

    exp_t         sb[$];
    int           errors   = 0;
    int           checks   = 0;
    logic [W-1:0] mdl_hi   = '0;
    logic [W-1:0] mdl_lo   = '0;
    int           busy_cnt = 0;
    logic         hold_bad = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit push, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                         input bit edz, input int lat, input bit hold);
        exp_t e;
        e.hi   = ehi;
        e.lo   = elo;
        e.dz   = edz;
        e.cyc  = cyc + 1 + lat;
        e.busy = lat;
        start  = 1'b1;
        op     = o;
        a      = x;
        b      = y;
        if (push) sb.push_back(e);
        if (!hold) begin
            step;
            start = 1'b0;
            op    = 3'($urandom_range(7));
            a     = W'($urandom);
            b     = W'($urandom);
        end
    endtask

    task automatic wait_done;
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            step;
            n++;
        end
        start = 1'b0;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        step;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            busy_cnt = 0;
            hold_bad = 1'b0;
            mdl_hi   = '0;
            mdl_lo   = '0;
        end else begin
            if (busy) begin
                busy_cnt++;
                if (hi !== mdl_hi || lo !== mdl_lo) hold_bad = 1'b1;
            end
            if (divZero && !done) begin
                checks++;
                errors++;
                $display("FAIL dz_without_done: got 1 expected 0");
            end
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done: got 1 expected 0 at cycle %0d", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("hi", 64'(hi), 64'(e.hi));
                    chk("lo", 64'(lo), 64'(e.lo));
                    chk("divZero", 64'(divZero), 64'(e.dz));
                    chk("done_cycle", 64'(cyc), 64'(e.cyc));
                    chk("busy_cycles", 64'(busy_cnt), 64'(e.busy));
                    chk("hilo_hold", 64'(hold_bad), 64'd0);
                    mdl_hi = e.hi;
                    mdl_lo = e.lo;
                end
                busy_cnt = 0;
                hold_bad = 1'b0;
            end
        end
    end

    initial begin
        step;
        step;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dz", 64'(divZero), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        reset = 1'b0;

        issue(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h00000001, 0, c_lat, 0); wait_done;
        issue(3'b001, 32'hFFFFFFFA, 32'h0000000B, 1, 32'hFFFFFFFF, 32'hFFFFFFBE, 0, c_lat, 0); wait_done;
        issue(3'b011, 32'hFFFFFFF9, 32'h00000002, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, c_lat, 0); wait_done;
        issue(3'b011, 32'h80000000, 32'hFFFFFFFF, 1, 32'h00000000, 32'h80000000, 0, c_lat, 0); wait_done;
        issue(3'b101, 32'h00000006, 32'h00000000, 1, 32'h00000000, 32'h00000006, 0, 0, 0);     wait_done;
        issue(3'b010, 32'h0000000B, 32'h00000000, 1, 32'h00000000, 32'h00000006, 1, 0, 0);     wait_done;
        issue(3'b100, 32'h12345678, 32'h00000000, 1, 32'h12345678, 32'h00000006, 0, 0, 0);     wait_done;

        issue(3'b110, 32'hDEADBEEF, 32'h00000001, 0, '0, '0, 0, 0, 0);
        repeat (5) step;
        chk("noop_hi", 64'(hi), 64'h12345678);
        chk("noop_lo", 64'(lo), 64'h00000006);
        chk("noop_busy", 64'(busy), 64'd0);

        issue(3'b010, 32'h00000006, 32'h0000000B, 1, 32'h00000006, 32'h00000000, 0, c_lat, 1); wait_done;
        repeat (40) step;

        issue(3'b010, 32'd100,      32'd7,        1, 32'h00000002, 32'h0000000E, 0, c_lat, 0); wait_done;
        issue(3'b011, 32'h00000007, 32'hFFFFFFFE, 1, 32'h00000001, 32'hFFFFFFFD, 0, c_lat, 0); wait_done;
        issue(3'b011, 32'hFFFFFFF9, 32'hFFFFFFFE, 1, 32'hFFFFFFFF, 32'h00000003, 0, c_lat, 0); wait_done;
        issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h00000000, 32'h00000001, 0, c_lat, 0); wait_done;
        issue(3'b001, 32'h80000000, 32'h80000000, 1, 32'h40000000, 32'h00000000, 0, c_lat, 0); wait_done;
        issue(3'b000, 32'h80000000, 32'h00000002, 1, 32'h00000001, 32'h00000000, 0, c_lat, 0); wait_done;
        issue(3'b011, 32'h00000005, 32'h00000000, 1, 32'h00000001, 32'h00000000, 1, 0, 0);     wait_done;
        issue(3'b101, 32'hA5A5A5A5, 32'h00000000, 1, 32'h00000001, 32'hA5A5A5A5, 0, 0, 0);     wait_done;

        issue(3'b001, 32'h00000007, 32'h00000009, 0, '0, '0, 0, c_lat, 0);
        repeat (9) step;
        reset = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        step;
        reset = 1'b0;
        issue(3'b000, 32'd3, 32'd5, 1, 32'h00000000, 32'h0000000F, 0, c_lat, 0); wait_done;
        repeat (5) step;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: operand and HI/LO register width; the iteration count equals WIDTH.
REQ-002 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-003 Port reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 Port start  in  1  request strobe, sampled on rising clk.
REQ-005 Port op  in  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO; 110 and 111 are no-ops.
REQ-006 Port a  in  WIDTH  multiplicand, dividend, or MTHI/MTLO source.
REQ-007 Port b  in  WIDTH  multiplier or divisor.
REQ-008 Port busy  out  1  iterating; the CPU stalls HI/LO consumers and new MDU ops while high.
REQ-009 Port done  out  1  one-cycle pulse when hi/lo hold the new result.
REQ-010 Port hi  out  WIDTH  HI register: product upper half or remainder.
REQ-011 Port lo  out  WIDTH  LO register: product lower half or quotient.
REQ-012 Port divZero  out  1  qualifies done; high when a DIV/DIVU had b==0.

Function
REQ-013 FSM states: IDLE, RUN, FIX, FIN.
- start is accepted only in IDLE; start in any other state is ignored, with no queuing.
REQ-014 Accepting MULT/MULTU/DIV/DIVU with a nonzero divisor (division) or any b (multiply):
- latch a, b and op;
- set the iteration counter to WIDTH;
- go to RUN.
REQ-015 RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle on magnitudes; the counter decrements each step; go to FIX after WIDTH steps.
REQ-016 FIX: one cycle applying sign correction for MULT/DIV; go to FIN.
REQ-017 busy is high in RUN and FIX only, i.e. WIDTH+1 cycles starting the cycle after acceptance.
REQ-018 FIN: hi and lo load on entry; done=1 for exactly one cycle; return to IDLE.
- Total latency from the accepting edge to done high: WIDTH+2 cycles (34 for WIDTH=32).
REQ-019 hi and lo keep their previous values throughout RUN and FIX; working registers are separate.
REQ-020 Unsigned ops treat a and b as unsigned.
- MULTU: {hi,lo} = a*b, full 2*WIDTH product.
- DIVU: lo = a/b, hi = a%b.
REQ-021 Signed ops use two's complement.
- MULT: {hi,lo} = signed product.
- DIV: quotient truncates toward zero; remainder takes the sign of the dividend.
REQ-022 DIV with a = -2^(WIDTH-1) and b = -1: lo = -2^(WIDTH-1), hi = 0, no exception flag.
REQ-023 DIV/DIVU accepted with b==0:
- no iteration and busy never asserts;
- hi and lo unchanged;
- go to FIN directly, so done=1 and divZero=1 on the cycle after acceptance.
REQ-024 divZero is 0 whenever done is 0, and 0 on any done that did not come from a zero divisor.
REQ-025 MTHI/MTLO accepted in IDLE:
- on the same edge hi<=a (MTHI) or lo<=a (MTLO), the other register unchanged;
- go to FIN, giving a done pulse the next cycle with no busy.
REQ-026 op 110/111 accepted in IDLE: no state change and no done.
REQ-027 start high in the FIN cycle is ignored; the next request can be accepted in the following IDLE cycle.
REQ-028 a, b and op may change freely after acceptance without affecting the running operation.

Reset
REQ-029 reset=1 immediately forces:
- state IDLE, counter 0;
- busy=0, done=0, divZero=0, hi=0, lo=0.
REQ-030 reset asserted during RUN, FIX or FIN aborts the operation with no done pulse and no partial result visible on hi/lo.
REQ-031 After reset deasserts, start is accepted on the first rising clk edge.

Verification
REQ-032 MULTU, a=0xFFFFFFFF, b=0xFFFFFFFF -> busy high for 33 cycles; done at cycle 34 with hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 MULT a=0xFFFFFFFA (-6), b=0x0000000B (11) -> hi=0xFFFFFFFF, lo=0xFFFFFFBE; then DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-034 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000, divZero=0.
REQ-035 MTLO a=6, then DIVU a=11, b=0 -> lo=6 after one edge with done; DIVU gives done+divZero the next cycle, no busy, hi/lo unchanged (lo=6).
REQ-036 DIVU a=0x6, b=0xB with start held high every cycle -> exactly one operation runs (lo=0, hi=6, single done); start pulses during busy ignored.
REQ-037 MULT started, reset asserted at cycle 10 -> busy, hi and lo read 0 immediately; no done; a fresh MULTU 3*5 then gives lo=15, hi=0 at latency 34.
